clock_edge_monitor: RTL

CLOCK_EDGE_MONITOR -- requirements
Module: clock_edge_monitor

---
 rtl/clock_edge_monitor.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/clock_edge_monitor.sv
// Edge detector and period/activity monitor for an asynchronous divided clock, sampled on clk_in.
// Optional macro CLOCK_EDGE_MONITOR_STICKY_LOST_EN keeps clk_lost set after recovery until disable or reset.
module clock_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                div_clk,
    input  logic                enable,
    output logic                rise_tick,
    output logic                fall_tick,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                clk_lost
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_t;

    // Edges are ignored until the synchronizer and history flop hold post-reset samples.
    localparam logic [2:0]          SETTLE    = 3'(SYNC_STAGES + 1);
    localparam logic [PERIOD_W-1:0] CNT_MAX   = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W-1:0] CNT_ZERO  = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic [2:0]             settle_r;
    state_t                 state_r;
    logic [PERIOD_W-1:0]    count_r;
    logic                   armed_s;
    logic                   rise_s;
    logic                   fall_s;
    logic [PERIOD_W-1:0]    count_inc_s;

    // Synchronizer chain and one-flop history; runs regardless of enable.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], div_clk};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Post-reset settle counter that arms edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            settle_r <= 3'd0;
        end else if (settle_r != SETTLE) begin
            settle_r <= settle_r + 3'd1;
        end else begin
            settle_r <= settle_r;
        end
    end

    // Edge detection and saturating counter increment.
    always_comb begin
        armed_s = (settle_r == SETTLE);
        rise_s  = armed_s & sync_r[SYNC_STAGES-1] & ~hist_r;
        fall_s  = armed_s & ~sync_r[SYNC_STAGES-1] & hist_r;
        if (count_r == CNT_MAX) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + CNT_ONE;
        end
    end

    // Registered one-cycle edge strobes, gated by enable.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            rise_tick <= enable & rise_s;
            fall_tick <= enable & fall_s;
        end
    end

    // Lock/measure/loss state machine; a rising edge takes priority over a timeout.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            count_r      <= CNT_ZERO;
            period       <= CNT_ZERO;
            period_valid <= 1'b0;
            clk_lost     <= 1'b0;
        end else if (!enable) begin
            state_r      <= IDLE;
            count_r      <= CNT_ZERO;
            period_valid <= 1'b0;
            clk_lost     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= ACQUIRE;
                    count_r <= CNT_ZERO;
                end
                ACQUIRE: begin
                    if (rise_s) begin
                        state_r <= LOCKED;
                        count_r <= CNT_ONE;
                    end else if (count_r == TIMEOUT_V) begin
                        state_r      <= LOST;
                        clk_lost     <= 1'b1;
                        period_valid <= 1'b0;
                    end else begin
                        count_r <= count_inc_s;
                    end
                end
                LOCKED: begin
                    if (rise_s) begin
                        period       <= count_r;
                        period_valid <= 1'b1;
                        count_r      <= CNT_ONE;
                    end else if (count_r == TIMEOUT_V) begin
                        state_r      <= LOST;
                        clk_lost     <= 1'b1;
                        period_valid <= 1'b0;
                    end else begin
                        count_r <= count_inc_s;
                    end
                end
                LOST: begin
                    if (rise_s) begin
                        state_r <= LOCKED;
                        count_r <= CNT_ONE;
`ifdef CLOCK_EDGE_MONITOR_STICKY_LOST_EN
                        clk_lost <= 1'b1;
`else
                        clk_lost <= 1'b0;
`endif
                    end else begin
                        state_r <= LOST;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    count_r      <= CNT_ZERO;
                    period_valid <= 1'b0;
                    clk_lost     <= 1'b0;
                end
            endcase
        end
    end

endmodule
